match_controller: RTL

//  Sequences one two-player rhythm-game match: idle, beat countdown, timed play round, result hold.

---
 rtl/match_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/match_controller.sv
// Two-player rhythm-game match sequencer: idle, beat countdown, timed play round, result hold.
// Tallies hit pulses into saturating scores and publishes final scores and a winner code.
module match_controller #(
  parameter int SCORE_W     = 5,
  parameter int WIN_SCORE   = 20,
  parameter int ROUND_BEATS = 64,
  parameter int COUNT_BEATS = 4,
  parameter int BEAT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              beat_tick,
  input  logic              hit1,
  input  logic              hit2,
  output logic [1:0]        state,
  output logic [2:0]        cd_left,
  output logic [BEAT_W-1:0] beat_num,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]        winner,
  output logic              play_active,
  output logic              match_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    RESULT    = 2'd3
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W:0]   WIN_L     = (SCORE_W+1)'(WIN_SCORE);
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(ROUND_BEATS - 1);
  localparam logic [2:0]         CD_INIT   = 3'(COUNT_BEATS);

  state_t            st;
  logic [SCORE_W:0]  sum1, sum2;
  logic [SCORE_W-1:0] s1_next, s2_next;
  logic              win1, win2, last_beat, end_round;
  logic [1:0]        winner_next;

  assign state = st;

  always_comb begin
    sum1        = {1'b0, score1} + {{SCORE_W{1'b0}}, hit1};
    sum2        = {1'b0, score2} + {{SCORE_W{1'b0}}, hit2};
    s1_next     = sum1[SCORE_W] ? SCORE_MAX : sum1[SCORE_W-1:0];
    s2_next     = sum2[SCORE_W] ? SCORE_MAX : sum2[SCORE_W-1:0];
    win1        = {1'b0, s1_next} >= WIN_L;
    win2        = {1'b0, s2_next} >= WIN_L;
    last_beat   = beat_num == LAST_BEAT;
    end_round   = win1 | win2 | (beat_tick & last_beat);
    winner_next = 2'd0;
    if (win1 | win2) begin
      if (s1_next > s2_next)      winner_next = 2'd1;
      else if (s2_next > s1_next) winner_next = 2'd2;
      else                        winner_next = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    match_done <= 1'b0;
    if (reset || abort) begin
      st          <= IDLE;
      cd_left     <= '0;
      beat_num    <= '0;
      score1      <= '0;
      score2      <= '0;
      winner      <= '0;
      play_active <= 1'b0;
    end else begin
      case (st)
        IDLE, RESULT: begin
          if (start) begin
            st       <= COUNTDOWN;
            cd_left  <= CD_INIT;
            beat_num <= '0;
            score1   <= '0;
            score2   <= '0;
            winner   <= '0;
          end
        end
        COUNTDOWN: begin
          if (beat_tick) begin
            if (cd_left == 3'd1) begin
              st          <= PLAY;
              cd_left     <= '0;
              beat_num    <= '0;
              play_active <= 1'b1;
            end else begin
              cd_left <= cd_left - 3'd1;
            end
          end
        end
        PLAY: begin
          score1 <= s1_next;
          score2 <= s2_next;
          // beat_num saturates at the last beat so RESULT shows the final beat index
          if (beat_tick && !last_beat) beat_num <= beat_num + 1'b1;
          if (end_round) begin
            st          <= RESULT;
            winner      <= winner_next;
            play_active <= 1'b0;
            match_done  <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
